// File: rtl/rom_fetch_arbiter.sv
// Round-robin burst read scheduler sharing one single-port memory between two requesters.
// Bursts issue one sequential, wrapping address per cycle and return words tagged with the requester ID.
module rom_fetch_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [LEN_WIDTH-1:0]  req0_len,
  input  logic [LEN_WIDTH-1:0]  req1_len,
  output logic                  req0_ready,
  output logic                  req1_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_clken,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_id,
  output logic                  done,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t               state, state_nxt;
  logic                 last_grant;
  logic                 grant_any, grant_id;
  logic                 issue_last;
  logic [LEN_WIDTH-1:0] len_q, cnt;
  logic                 id_q;
  logic                 issue_d1, last_d1;

  // Tie goes to whichever requester did not win the previous grant.
  always_comb begin
    grant_any  = req0_valid | req1_valid;
    grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    issue_last = (state == BURST) && (cnt == len_q);
    state_nxt  = state;
    case (state)
      IDLE:    if (grant_any)  state_nxt = BURST;
      BURST:   if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (done)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Return pipeline: issue -> memory q -> rd_data register, two cycles total.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant  <= 1'b1;
      id_q        <= 1'b0;
      len_q       <= '0;
      cnt         <= '0;
      mem_address <= '0;
      mem_clken   <= 1'b0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      issue_d1    <= 1'b0;
      last_d1     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_id       <= 1'b0;
      done        <= 1'b0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      issue_d1   <= mem_clken;
      last_d1    <= issue_last;
      rd_valid   <= issue_d1;
      done       <= last_d1;
      if (issue_d1) begin
        rd_data <= mem_readdata;
        rd_id   <= id_q;
      end
      case (state)
        IDLE: begin
          if (grant_any) begin
            last_grant  <= grant_id;
            id_q        <= grant_id;
            len_q       <= grant_id ? req1_len : req0_len;
            mem_address <= grant_id ? req1_addr : req0_addr;
            mem_clken   <= 1'b1;
            cnt         <= '0;
            req0_ready  <= ~grant_id;
            req1_ready  <= grant_id;
          end
        end
        BURST: begin
          if (issue_last) begin
            mem_clken <= 1'b0;
          end else begin
            mem_address <= mem_address + ADDR_WIDTH'(1);
            cnt         <= cnt + LEN_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed and randomized bench for rom_fetch_arbiter against a cycle-schedule reference model.
module tb_rom_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [11:0] req0_addr = '0, req1_addr = '0;
  logic [7:0]  req0_len = '0, req1_len = '0;
  logic        req0_ready, req1_ready;
  logic [11:0] mem_address;
  logic        mem_clken;
  logic [15:0] mem_readdata = '0;
  logic [15:0] rd_data;
  logic        rd_valid, rd_id, done, busy;

  rom_fetch_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .LEN_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_len(req0_len), .req1_len(req1_len),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .mem_address(mem_address), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port memory with one-cycle read latency.
  logic [15:0] mem [4096];
  always @(posedge clk) if (mem_clken) mem_readdata <= mem[mem_address];

  typedef struct {
    logic [15:0] d;
    logic        id;
    logic        last;
  } rd_t;

  // Expected events keyed by absolute cycle number.
  bit          er0 [int];
  bit          er1 [int];
  bit          ebusy [int];
  logic [11:0] eaddr [int];
  rd_t         erd [int];
  int          free_cyc;
  logic        ptr;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // A grant sampled at the end of cycle c schedules the whole burst's observable timeline.
  task automatic model_sample();
    logic        id;
    int          len;
    logic [11:0] a;
    if (reset || cyc < free_cyc) return;
    if (!req0_valid && !req1_valid) return;
    id  = (req0_valid && req1_valid) ? ~ptr : req1_valid;
    ptr = id;
    a   = id ? req1_addr : req0_addr;
    len = int'(id ? req1_len : req0_len) + 1;
    if (id) er1[cyc+1] = 1'b1;
    else    er0[cyc+1] = 1'b1;
    for (int k = 0; k < len; k++) begin
      eaddr[cyc+1+k] = a;
      erd[cyc+3+k]   = '{mem[a], id, (k == len-1)};
      a = a + 12'd1;
    end
    for (int k = 1; k <= len+2; k++) ebusy[cyc+k] = 1'b1;
    free_cyc = cyc + len + 3;
  endtask

  task automatic check_cycle();
    chk("ready0", 32'(req0_ready), 32'(er0.exists(cyc)));
    chk("ready1", 32'(req1_ready), 32'(er1.exists(cyc)));
    chk("busy", 32'(busy), 32'(ebusy.exists(cyc)));
    chk("clken", 32'(mem_clken), 32'(eaddr.exists(cyc)));
    if (eaddr.exists(cyc)) chk("addr", 32'(mem_address), 32'(eaddr[cyc]));
    chk("rd_valid", 32'(rd_valid), 32'(erd.exists(cyc)));
    if (erd.exists(cyc)) begin
      chk("rd_data", 32'(rd_data), 32'(erd[cyc].d));
      chk("rd_id", 32'(rd_id), 32'(erd[cyc].id));
      chk("done", 32'(done), 32'(erd[cyc].last));
    end else begin
      chk("done_idle", 32'(done), 32'd0);
    end
  endtask

  task automatic tick();
    model_sample();
    @(posedge clk);
    cyc++;
    #1;
    check_cycle();
    if (er0.exists(cyc)) req0_valid = 1'b0;
    if (er1.exists(cyc)) req1_valid = 1'b0;
  endtask

  task automatic req(input bit id, input logic [11:0] a, input logic [7:0] l);
    if (id) begin req1_valid = 1'b1; req1_addr = a; req1_len = l; end
    else    begin req0_valid = 1'b1; req0_addr = a; req0_len = l; end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400 && cyc < free_cyc; n++) tick();
  endtask

  function automatic logic [7:0] rand_len();
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 7));
  endfunction

  initial begin
    int g;
    int bcount;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem[16] = 16'hBEEF;
    ptr = 1'b1;
    free_cyc = 1 << 30;

    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    free_cyc = cyc;

    // Single-word burst at 0x010
    req(0, 12'h010, 8'd0);
    repeat (6) tick();

    // Wrapping burst from requester 1
    req(1, 12'hFFE, 8'd3);
    repeat (9) tick();

    // Both held continuously: alternating grants
    for (int n = 0; n < 24; n++) begin
      if (!req0_valid) req(0, 12'($urandom), 8'd1);
      if (!req1_valid) req(1, 12'($urandom), 8'd1);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();

    // Longest burst; busy spans len+3 cycles minus one
    req(0, 12'h100, 8'd255);
    bcount = 0;
    for (int n = 0; n < 270; n++) begin
      tick();
      if (busy) bcount++;
    end
    chk("busy_len", 32'(bcount), 32'd258);

    // Asynchronous reset at issue i=5 of a len=9 burst
    wait_idle();
    req(0, 12'($urandom), 8'd9);
    g = cyc;
    tick();
    while (cyc < g + 6) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_clken", 32'(mem_clken), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_id", 32'(rd_id), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    er0.delete(); er1.delete(); ebusy.delete(); eaddr.delete(); erd.delete();
    ptr = 1'b1;
    free_cyc = 1 << 30;
    req(0, 12'h2A0, 8'd2);
    repeat (2) tick();
    reset = 1'b0;
    free_cyc = cyc;
    repeat (10) tick();

    // Requester 1 arrives during requester 0's drain
    wait_idle();
    req(0, 12'($urandom), 8'd2);
    g = cyc;
    tick();
    while (cyc < g + 4) tick();
    req(1, 12'($urandom), 8'd0);
    repeat (12) tick();

    // Randomized traffic with occasional withdrawn requests
    for (int n = 0; n < 1500; n++) begin
      tick();
      if (!req0_valid) begin
        if ($urandom_range(0, 3) == 0) req(0, 12'($urandom), rand_len());
      end else if ($urandom_range(0, 29) == 0) begin
        req0_valid = 1'b0;
      end
      if (!req1_valid) begin
        if ($urandom_range(0, 3) == 0) req(1, 12'($urandom), rand_len());
      end else if ($urandom_range(0, 29) == 0) begin
        req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
